// File: rtl/expr_string_rx_pkg.sv
// expr_pkg: state/class encodings and character constants shared by the
// expr_string_rx recogniser and its character classifier.
package expr_pkg;

   typedef enum logic [2:0] {
      S_START,
      S_NUM,
      S_TERM,
      S_OP,
      S_ERR
   } state_t;

   typedef enum logic [2:0] {
      C_DIGIT,
      C_OP,
      C_LPAR,
      C_RPAR,
      C_SPACE,
      C_BAD
   } cls_t;

   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_ADD   = 8'h2B;
   localparam logic [7:0] CH_SUB   = 8'h2D;
   localparam logic [7:0] CH_MUL   = 8'h2A;
   localparam logic [7:0] CH_DIV   = 8'h2F;
   localparam logic [7:0] CH_LPAR  = 8'h28;
   localparam logic [7:0] CH_RPAR  = 8'h29;
   localparam logic [7:0] CH_SPACE = 8'h20;

   function automatic logic is_op(input logic [7:0] c);
      return (c == CH_ADD) || (c == CH_SUB) || (c == CH_MUL) || (c == CH_DIV);
   endfunction

endpackage

// File: rtl/expr_string_rx_if.sv
// Character stream in, recogniser status out. master = character source,
// slave = expr_string_rx.
interface expr_string_rx_if #(
   parameter int W  = 8,
   parameter int DW = 3
);
   logic          restart;
   logic          in_valid;
   logic [W-1:0]  in;
   logic          out;
   logic          err;
   logic [15:0]   num_cnt;
   logic [DW-1:0] depth;

   modport master (output restart, in_valid, in,
                   input  out, err, num_cnt, depth);
   modport slave  (input  restart, in_valid, in,
                   output out, err, num_cnt, depth);
endinterface

// File: rtl/expr_string_rx_char_class.sv
// char_class: combinational character -> class decoder. Space is only a
// separator when SKIP_SPACE != 0; parentheses are only legal with EXPR_PAREN_EN.
module char_class
   import expr_pkg::*;
#(
   parameter int W          = 8,
   parameter int SKIP_SPACE = 1
) (
   input  logic [W-1:0] ch,
   output cls_t         cls
);

   logic       hi;
   logic [7:0] c;

   assign c = ch[7:0];

   // Anything outside 7-bit ASCII is illegal regardless of the low byte.
   generate
      if (W > 8) begin : g_hi
         assign hi = |ch[W-1:8];
      end else begin : g_nohi
         assign hi = 1'b0;
      end
   endgenerate

   always_comb begin
      cls = C_BAD;
      if (!hi) begin
         if (c >= CH_0 && c <= CH_9)               cls = C_DIGIT;
         else if (is_op(c))                        cls = C_OP;
         else if (c == CH_SPACE && SKIP_SPACE != 0) cls = C_SPACE;
`ifdef EXPR_PAREN_EN
         else if (c == CH_LPAR)                    cls = C_LPAR;
         else if (c == CH_RPAR)                    cls = C_RPAR;
`endif
      end
   end

endmodule

// File: rtl/expr_string_rx.sv
// expr_string_rx: streaming infix-expression recogniser, one char per valid
// beat. Parenthesis nesting and the depth counter exist only with EXPR_PAREN_EN.
module expr_string_rx
   import expr_pkg::*;
#(
   parameter int W          = 8,
   parameter int MAX_DIGITS = 4,
   parameter int MAX_DEPTH  = 7,
   parameter int SKIP_SPACE = 1
) (
   input  logic             clk,
   input  logic             clr,
   expr_string_rx_if.slave  bus
);

   localparam int DW = $clog2(MAX_DEPTH + 1);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [DW-1:0] DMAX   = DW'(MAX_DEPTH);
   localparam logic [CW-1:0] DIGMAX = CW'(MAX_DIGITS);

   cls_t          cls;
   state_t        state_q, state_n;
   logic [CW-1:0] dcnt_q, dcnt_n;
   logic [15:0]   num_q, num_n;
   logic [DW-1:0] depth_q, depth_n;
   logic          out_q, err_q;
   logic          out_n;

   char_class #(.W(W), .SKIP_SPACE(SKIP_SPACE)) u_cls (
      .ch  (bus.in),
      .cls (cls)
   );

   always_comb begin
      state_n = state_q;
      dcnt_n  = dcnt_q;
      num_n   = num_q;
      depth_n = depth_q;
      case (state_q)
         S_START, S_OP: begin
            case (cls)
               C_DIGIT: begin
                  state_n = S_NUM;
                  dcnt_n  = CW'(1);
                  if (num_q != 16'hFFFF) num_n = num_q + 16'd1;
               end
               C_LPAR: begin
                  if (depth_q == DMAX) state_n = S_ERR;
                  else begin
                     state_n = S_START;
                     depth_n = depth_q + DW'(1);
                  end
               end
               C_SPACE: state_n = state_q;
               default: state_n = S_ERR;
            endcase
         end
         S_NUM, S_TERM: begin
            case (cls)
               C_DIGIT: begin
                  // A digit after a separator or ')' would start a second operand.
                  if (state_q == S_TERM || dcnt_q == DIGMAX) state_n = S_ERR;
                  else dcnt_n = dcnt_q + CW'(1);
               end
               C_OP: state_n = S_OP;
               C_RPAR: begin
                  if (depth_q == '0) state_n = S_ERR;
                  else begin
                     state_n = S_TERM;
                     depth_n = depth_q - DW'(1);
                  end
               end
               C_SPACE: state_n = S_TERM;
               default: state_n = S_ERR;
            endcase
         end
         default: state_n = S_ERR;
      endcase
   end

   assign out_n = (state_n == S_NUM || state_n == S_TERM) && (depth_n == '0);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_START;
         dcnt_q  <= '0;
         num_q   <= '0;
         out_q   <= 1'b0;
         err_q   <= 1'b0;
      end else if (bus.restart) begin
         state_q <= S_START;
         dcnt_q  <= '0;
         num_q   <= '0;
         out_q   <= 1'b0;
         err_q   <= 1'b0;
      end else if (bus.in_valid) begin
         state_q <= state_n;
         dcnt_q  <= dcnt_n;
         num_q   <= num_n;
         out_q   <= out_n;
         err_q   <= (state_n == S_ERR);
      end
   end

`ifdef EXPR_PAREN_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)              depth_q <= '0;
      else if (bus.restart)  depth_q <= '0;
      else if (bus.in_valid) depth_q <= depth_n;
   end
`else
   assign depth_q = '0;
`endif

   assign bus.out     = out_q;
   assign bus.err     = err_q;
   assign bus.num_cnt = num_q;
   assign bus.depth   = depth_q;

endmodule
